// File: rtl/sync_fifo_v2_if.sv
// Producer/consumer bundle for sync_fifo_v2: write side, read side, thresholds and status.
// The FIFO is the slave; the logic that feeds and drains it is the master.
interface sync_fifo_v2_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_WIDTH = 8
);
  localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1);

  logic                  wren;
  logic [FIFO_WIDTH-1:0] wrdata;
  logic                  rden;
  logic [CNT_WIDTH-1:0]  af_thresh;
  logic [CNT_WIDTH-1:0]  ae_thresh;
  logic                  err_clr;
  logic [FIFO_WIDTH-1:0] rddata;
  logic                  rd_valid;
  logic                  full;
  logic                  almost_full;
  logic                  empty;
  logic                  almost_empty;
  logic [CNT_WIDTH-1:0]  fill_cnt;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wren, wrdata, rden, af_thresh, ae_thresh, err_clr,
    input  rddata, rd_valid, full, almost_full, empty, almost_empty,
           fill_cnt, overflow, underflow
  );

  modport slave (
    input  wren, wrdata, rden, af_thresh, ae_thresh, err_clr,
    output rddata, rd_valid, full, almost_full, empty, almost_empty,
           fill_cnt, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO, any depth >= 2, registered-read or first-word-fall-through,
// with programmable almost flags, fill count and sticky overflow/underflow.
module sync_fifo_v2 #(
  parameter int FIFO_DEPTH    = 4,
  parameter int FIFO_WIDTH    = 8,
  parameter int FWFT_MODE     = 0,
  parameter int EN_ALMOST_FLG = 1,
  localparam int CNT_WIDTH    = $clog2(FIFO_DEPTH + 1)
) (
  input logic           clk,
  input logic           rst,
  sync_fifo_v2_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  full, empty, wr_acc, rd_acc;

  assign full   = (cnt_q == CNT_FULL);
  assign empty  = (cnt_q == '0);
  assign wr_acc = bus.wren & ~full;
  assign rd_acc = bus.rden & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    // Explicit wrap keeps non-power-of-two depths correct.
    if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
    if (wr_acc && !rd_acc)      cnt_d = cnt_q + CNT_ONE;
    else if (rd_acc && !wr_acc) cnt_d = cnt_q - CNT_ONE;
    if (bus.err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    // A new error event outranks a clear in the same cycle.
    if (bus.wren && full)  ovf_d = 1'b1;
    if (bus.rden && empty) udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= bus.wrdata;
  end

  generate
    if (FWFT_MODE != 0) begin : g_fwft
      assign bus.rddata   = mem_q[rd_ptr_q];
      assign bus.rd_valid = ~empty;
    end else begin : g_std
      logic [FIFO_WIDTH-1:0] rddata_q, rddata_d;
      logic                  rd_valid_q, rd_valid_d;

      always_comb begin
        rddata_d   = rddata_q;
        rd_valid_d = rd_acc;
        if (rd_acc) rddata_d = mem_q[rd_ptr_q];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rddata_q   <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rddata_q   <= rddata_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign bus.rddata   = rddata_q;
      assign bus.rd_valid = rd_valid_q;
    end
  endgenerate

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.fill_cnt     = cnt_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
  assign bus.almost_full  = (EN_ALMOST_FLG != 0) && (cnt_q >= bus.af_thresh);
  assign bus.almost_empty = (EN_ALMOST_FLG != 0) && (cnt_q <= bus.ae_thresh);
endmodule

// File: tb/tb_sync_fifo_v2.sv
// Directed bench for sync_fifo_v2: depth-5 standard and FWFT instances, plus
// depth-8 instances with almost flags enabled and disabled sharing one stimulus.
module tb_sync_fifo_v2;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] exp_tail [4];

  always #5 clk = ~clk;

  sync_fifo_v2_if #(.FIFO_DEPTH(5), .FIFO_WIDTH(8)) if0 ();
  sync_fifo_v2_if #(.FIFO_DEPTH(5), .FIFO_WIDTH(8)) if1 ();
  sync_fifo_v2_if #(.FIFO_DEPTH(8), .FIFO_WIDTH(8)) if2 ();
  sync_fifo_v2_if #(.FIFO_DEPTH(8), .FIFO_WIDTH(8)) if3 ();

  sync_fifo_v2 #(.FIFO_DEPTH(5), .FIFO_WIDTH(8), .FWFT_MODE(0), .EN_ALMOST_FLG(1))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  sync_fifo_v2 #(.FIFO_DEPTH(5), .FIFO_WIDTH(8), .FWFT_MODE(1), .EN_ALMOST_FLG(1))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  sync_fifo_v2 #(.FIFO_DEPTH(8), .FIFO_WIDTH(8), .FWFT_MODE(0), .EN_ALMOST_FLG(1))
    u2 (.clk(clk), .rst(rst), .bus(if2));
  sync_fifo_v2 #(.FIFO_DEPTH(8), .FIFO_WIDTH(8), .FWFT_MODE(0), .EN_ALMOST_FLG(0))
    u3 (.clk(clk), .rst(rst), .bus(if3));

  assign if3.wren      = if2.wren;
  assign if3.wrdata    = if2.wrdata;
  assign if3.rden      = if2.rden;
  assign if3.af_thresh = if2.af_thresh;
  assign if3.ae_thresh = if2.ae_thresh;
  assign if3.err_clr   = if2.err_clr;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_tail = '{8'h05, 8'hA0, 8'hA1, 8'hA2};
    rst = 1'b1;
    if0.wren = 0; if0.wrdata = 0; if0.rden = 0; if0.err_clr = 0;
    if0.af_thresh = 3'd4; if0.ae_thresh = 3'd1;
    if1.wren = 0; if1.wrdata = 0; if1.rden = 0; if1.err_clr = 0;
    if1.af_thresh = 3'd4; if1.ae_thresh = 3'd1;
    if2.wren = 0; if2.wrdata = 0; if2.rden = 0; if2.err_clr = 0;
    if2.af_thresh = 4'd6; if2.ae_thresh = 4'd2;
    cyc();
    cyc();
    rst = 1'b0;

    // Reset state
    chk("rst_fill", if0.fill_cnt, 0);
    chk("rst_empty", if0.empty, 1);
    chk("rst_full", if0.full, 0);
    chk("rst_ovf", if0.overflow, 0);
    chk("rst_udf", if0.underflow, 0);
    chk("rst_rdv", if0.rd_valid, 0);
    chk("rst_rddata", if0.rddata, 0);
    chk("rst_ae", if0.almost_empty, 1);
    chk("rst_af", if0.almost_full, 0);
    chk("rst_fwft_rdv", if1.rd_valid, 0);
    chk("rst_noalm_ae", if3.almost_empty, 0);

    // Fill depth 5, then one write too many
    for (int i = 1; i <= 5; i++) begin
      if0.wren = 1; if0.wrdata = 8'(i);
      cyc();
      chk("fill_cnt", if0.fill_cnt, i);
    end
    chk("fill_full", if0.full, 1);
    chk("fill_af", if0.almost_full, 1);
    if0.wrdata = 8'h06;
    cyc();
    if0.wren = 0;
    chk("ovf_set", if0.overflow, 1);
    chk("ovf_fill", if0.fill_cnt, 5);

    // Read three, one-cycle latency each
    if0.rden = 1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("rd_data", if0.rddata, i);
      chk("rd_valid", if0.rd_valid, 1);
    end
    if0.rden = 0;
    cyc();
    chk("rd_pulse_end", if0.rd_valid, 0);
    chk("rd_hold", if0.rddata, 8'h03);
    chk("rd_fill", if0.fill_cnt, 2);

    // Wrap the write pointer
    for (int i = 0; i < 3; i++) begin
      if0.wren = 1; if0.wrdata = 8'hA0 + 8'(i);
      cyc();
    end
    if0.wren = 0;
    chk("wrap_full", if0.full, 1);
    if0.err_clr = 1;
    cyc();
    if0.err_clr = 0;
    chk("clr_ovf", if0.overflow, 0);

    // Simultaneous read/write while full
    if0.wren = 1; if0.wrdata = 8'hBB; if0.rden = 1;
    cyc();
    if0.wren = 0;
    chk("full_rw_data", if0.rddata, 8'h04);
    chk("full_rw_fill", if0.fill_cnt, 4);
    chk("full_rw_ovf", if0.overflow, 1);
    chk("full_rw_full", if0.full, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("tail_data", if0.rddata, exp_tail[i]);
    end
    if0.rden = 0;
    chk("tail_empty", if0.empty, 1);
    cyc();
    chk("tail_rdv", if0.rd_valid, 0);

    // Simultaneous read/write while empty
    if0.wren = 1; if0.wrdata = 8'hC1; if0.rden = 1;
    cyc();
    if0.wren = 0; if0.rden = 0;
    chk("empty_rw_fill", if0.fill_cnt, 1);
    chk("empty_rw_udf", if0.underflow, 1);
    chk("empty_rw_rdv", if0.rd_valid, 0);
    if0.rden = 1;
    cyc();
    chk("empty_rw_data", if0.rddata, 8'hC1);
    chk("empty_rw_fill0", if0.fill_cnt, 0);

    // Error clear vs. set priority
    if0.err_clr = 1;
    cyc();
    chk("clr_vs_udf", if0.underflow, 1);
    chk("clr_ovf2", if0.overflow, 0);
    if0.rden = 0;
    cyc();
    if0.err_clr = 0;
    chk("clr_udf", if0.underflow, 0);

    // Sustained read+write at fill 2
    if0.wren = 1; if0.wrdata = 8'hD0;
    cyc();
    if0.wrdata = 8'hD1;
    cyc();
    if0.rden = 1;
    for (int i = 0; i < 10; i++) begin
      if0.wrdata = 8'hD2 + 8'(i);
      cyc();
      chk("stream_fill", if0.fill_cnt, 2);
      chk("stream_data", if0.rddata, 8'hD0 + 8'(i));
    end
    if0.rden = 0;
    if0.wrdata = 8'hE0;
    cyc();
    if0.wren = 0;
    chk("pre_rst_fill", if0.fill_cnt, 3);

    // FWFT instance
    if1.wren = 1; if1.wrdata = 8'h55;
    cyc();
    if1.wren = 0;
    chk("fwft_rdv", if1.rd_valid, 1);
    chk("fwft_data", if1.rddata, 8'h55);
    if1.rden = 1;
    cyc();
    if1.rden = 0;
    chk("fwft_rdv_off", if1.rd_valid, 0);
    if1.wren = 1; if1.wrdata = 8'h11;
    cyc();
    if1.wrdata = 8'h22;
    cyc();
    if1.wren = 0;
    chk("fwft_first", if1.rddata, 8'h11);
    if1.rden = 1;
    cyc();
    chk("fwft_second", if1.rddata, 8'h22);
    chk("fwft_rdv2", if1.rd_valid, 1);
    cyc();
    if1.rden = 0;
    chk("fwft_drained", if1.rd_valid, 0);

    // Almost thresholds, depth 8, af=6 ae=2
    chk("thr_ae0", if2.almost_empty, 1);
    chk("thr_af0", if2.almost_full, 0);
    for (int k = 1; k <= 7; k++) begin
      if2.wren = 1; if2.wrdata = 8'(k);
      cyc();
      chk("thr_ae", if2.almost_empty, (k <= 2) ? 1 : 0);
      chk("thr_af", if2.almost_full, (k >= 6) ? 1 : 0);
      chk("noalm_ae", if3.almost_empty, 0);
      chk("noalm_af", if3.almost_full, 0);
      if (k == 4) begin
        if2.af_thresh = 4'd3;
        #1;
        chk("thr_af_live", if2.almost_full, 1);
        chk("noalm_af_live", if3.almost_full, 0);
        if2.af_thresh = 4'd6;
        #1;
        chk("thr_af_back", if2.almost_full, 0);
      end
    end
    if2.wren = 0;
    if2.ae_thresh = 4'd8;
    #1;
    chk("thr_ae_force", if2.almost_empty, 1);
    if2.ae_thresh = 4'd2;
    #1;
    chk("thr_ae_back", if2.almost_empty, 0);

    // Reset beats a concurrent write
    rst = 1; if0.wren = 1; if0.wrdata = 8'hFF;
    cyc();
    rst = 0; if0.wren = 0;
    chk("rstw_fill", if0.fill_cnt, 0);
    chk("rstw_empty", if0.empty, 1);
    chk("rstw_rddata", if0.rddata, 0);
    cyc();
    chk("rstw_nowrite", if0.fill_cnt, 0);
    if2.af_thresh = 4'd0;
    #1;
    chk("af_zero", if2.almost_full, 1);
    chk("noalm_af_zero", if3.almost_full, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo_v2.md
# sync_fifo_v2

Parametrised single-clock FIFO for buffering data between producer and consumer logic in the same clock domain. It supports any depth of 2 or more, including non-power-of-two depths. A parameter selects either a standard registered-read mode or a first-word-fall-through (FWFT) mode. It also provides runtime-programmable almost-full/almost-empty thresholds, a fill-count output, and sticky overflow/underflow error flags.

## Interface
Parameters:
- FIFO_DEPTH, 4: number of entries; legal range ≥ 2, any integer.
- FIFO_WIDTH, 8: data width in bits, ≥ 1.
- FWFT_MODE, 0: 0 selects standard registered read; 1 selects first-word-fall-through.
- EN_ALMOST_FLG, 1: 1 enables the almost flags; 0 ties almost_full and almost_empty to 0.
- CNT_WIDTH, $clog2(FIFO_DEPTH+1): derived, not overridable; width of counts and thresholds.

Ports:
- clk, input, 1: the single clock; everything is sampled on the rising edge.
- rst, input, 1: reset; **synchronous, active-high**.
- wren, input, 1: write request.
- wrdata, input, FIFO_WIDTH: write data.
- rden, input, 1: read request (pop).
- af_thresh, input, CNT_WIDTH: almost-full threshold.
- ae_thresh, input, CNT_WIDTH: almost-empty threshold.
- err_clr, input, 1: clears overflow and underflow.
- rddata, output, FIFO_WIDTH: read data.
- rd_valid, output, 1: rddata is valid.
- full, output, 1: FIFO full.
- almost_full, output, 1: fill_cnt ≥ af_thresh.
- empty, output, 1: FIFO empty.
- almost_empty, output, 1: fill_cnt ≤ ae_thresh.
- fill_cnt, output, CNT_WIDTH: number of occupied entries.
- overflow, output, 1: sticky; a write was attempted while full.
- underflow, output, 1: sticky; a read was attempted while empty.

## Operation
- Accepted write: wr_acc = wren & !full. It stores wrdata at wr_ptr and advances wr_ptr.
- Accepted read: rd_acc = rden & !empty. It advances rd_ptr.
- Pointers are $clog2(FIFO_DEPTH) bits wide. Each wraps explicitly from FIFO_DEPTH-1 to 0; there is no reliance on binary rollover.
- fill_cnt update each cycle:
  - +1 on wr_acc only.
  - −1 on rd_acc only.
  - Unchanged when both or neither occur.
  - Never exceeds FIFO_DEPTH and never goes below 0.
- Status flags:
  - full = (fill_cnt == FIFO_DEPTH).
  - empty = (fill_cnt == 0).
  - Both are decoded combinationally from the registered count.
- Simultaneous wren and rden:
  - When full: the read is accepted and the write is rejected.
  - When empty: the write is accepted and the read is rejected.
  - No bypass path exists from write to read in either case.
- Rejected writes discard the data; memory and pointers are unchanged.
- Almost flags (when EN_ALMOST_FLG=1):
  - Compared combinationally against the current threshold inputs.
  - Thresholds may change at any time and take effect in the same cycle.
  - af_thresh = 0 forces almost_full = 1.
  - ae_thresh ≥ FIFO_DEPTH forces almost_empty = 1.
- Error flags:
  - overflow is set by wren & full; underflow is set by rden & empty.
  - err_clr clears both.
  - A set event in the same cycle as err_clr wins, so the flag stays 1.
- FWFT_MODE=0 (standard read):
  - rddata is a register loaded with mem[rd_ptr] on rd_acc.
  - rd_valid is a one-cycle pulse in the cycle after rd_acc.
  - rddata holds its last value otherwise.
- FWFT_MODE=1 (first-word-fall-through):
  - rddata = mem[rd_ptr] (combinational from storage).
  - rd_valid = !empty.
  - rden acknowledges the displayed word; the next word appears in the cycle after rd_acc.
  - rddata is don't-care while rd_valid=0.
- Storage array is not reset.

## Timing
- Reset (rst=1 at a rising edge) forces the following on the next cycle:
  - wr_ptr = rd_ptr = fill_cnt = 0.
  - empty=1, full=0, almost_full=0 (unless af_thresh=0), almost_empty=EN_ALMOST_FLG.
  - overflow=0, underflow=0, rd_valid=0.
  - rddata=0 in mode 0.
- Reset overrides wren, rden and err_clr in the same cycle.
- Reset mid-operation discards all contents.
- Write-to-empty-deassert latency is 1 cycle: a write accepted at edge N gives empty=0 after edge N.
  - In FWFT mode, the data is valid on rddata in that same cycle.
- Mode 0 read latency is 1 cycle: rden at edge N gives rddata/rd_valid after edge N.
- full asserts in the cycle after the write that fills the last entry; it deasserts in the cycle after the first accepted read.
- Sustained simultaneous read and write at any non-empty, non-full level gives full throughput (one word per clock) with fill_cnt constant.

## Test plan
- **Reset and fill, depth 5, mode 0:**
  - Stimulus: reset, then write 0x01..0x05 on consecutive cycles, then 1 more write.
  - Required: fill_cnt goes 0→5, full=1 after the 5th write, the 6th write sets overflow=1, and fill_cnt stays 5.
- **Wrap-around, depth 5, mode 0:**
  - Stimulus: write 0x01..0x05, read 3, write 0xA0..0xA2, then read 5.
  - Required: read order is 0x01,0x02,0x03 then 0x04,0x05,0xA0,0xA1,0xA2; each rd_valid pulse is 1 cycle after its rden; empty=1 at the end.
- **FWFT mode:**
  - Stimulus: write 0x55 into the empty FIFO.
  - Required: in the next cycle rd_valid=1 and rddata=0x55; after rden, rd_valid=0 the following cycle.
  - Then: write 0x11 and 0x22, hold rden=1 for 2 cycles; rddata shows 0x11, then 0x22.
- **Simultaneous read/write:**
  - At fill 2: wren=rden=1 for 10 cycles gives fill_cnt stays 2 and data order is preserved.
  - When full: read accepted, write rejected, overflow=1, fill_cnt=4 for depth 5.
  - When empty: fill_cnt becomes 1 and underflow=1.
- **Thresholds:**
  - Setup: depth 8, af_thresh=6, ae_thresh=2.
  - Filling: almost_empty=1 for fill_cnt 0..2; almost_full=1 from fill_cnt 6.
  - Changing af_thresh to 3 at fill 4 sets almost_full=1 in the same cycle.
  - With EN_ALMOST_FLG=0, both almost flags stay 0 throughout.
- **Error clear and reset priority:**
  - err_clr together with rden-on-empty leaves underflow=1.
  - err_clr alone clears the flags next cycle.
  - Asserting rst together with wren while at fill 3 gives fill_cnt=0, empty=1, and no write.
